aes_job_arbiter: RTL

Shares one AES decryption core between `NUM_REQ` hardware requesters. Jobs are granted round-robin, and each job's key and ciphertext are latched. The arbiter sequences the core's level-sensitive `AES_START`/`AES_DONE` handshake and returns the plaintext to the originating requester over a valid/ready response channel. It sits between the requester-side logic (Avalon register interface, sprite/asset decoders) and the single `AES` instance, replacing direct register-driven control of `AES_START`.

---
 rtl/aes_job_arbiter_if.sv | 39 +++
 rtl/aes_job_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/aes_job_arbiter_if.sv
// Bundles the requester-side job/response channels and the AES core handshake
// into one interface. Clock, reset and status outputs stay plain ports.
//
// Signals (NUM_REQ = number of requesters):
//   REQ_VALID/REQ_READY  job request and one-hot accept pulse, per requester
//   REQ_KEY/REQ_MSG      packed 128-bit key/ciphertext, requester i at [128i+127:128i]
//   RSP_VALID/RSP_READY  one-hot response valid and per-requester accept
//   RSP_DATA/RSP_ERR     plaintext (0 on abort) and timeout-abort flag
//   AES_START/AES_DONE   level handshake with the shared core
//   AES_KEY/AES_MSG_ENC  job operands to the core
//   AES_MSG_DEC          plaintext from the core
// Modports: slave = the arbiter, master = requesters plus core.
interface aes_job_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]     REQ_VALID;
    logic [NUM_REQ-1:0]     REQ_READY;
    logic [NUM_REQ*128-1:0] REQ_KEY;
    logic [NUM_REQ*128-1:0] REQ_MSG;
    logic [NUM_REQ-1:0]     RSP_VALID;
    logic [NUM_REQ-1:0]     RSP_READY;
    logic [127:0]           RSP_DATA;
    logic                   RSP_ERR;
    logic                   AES_START;
    logic [127:0]           AES_KEY;
    logic [127:0]           AES_MSG_ENC;
    logic                   AES_DONE;
    logic [127:0]           AES_MSG_DEC;

    modport slave (
        input  REQ_VALID, REQ_KEY, REQ_MSG, RSP_READY, AES_DONE, AES_MSG_DEC,
        output REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR, AES_START, AES_KEY, AES_MSG_ENC
    );

    modport master (
        output REQ_VALID, REQ_KEY, REQ_MSG, RSP_READY, AES_DONE, AES_MSG_DEC,
        input  REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR, AES_START, AES_KEY, AES_MSG_ENC
    );
endinterface

// File: rtl/aes_job_arbiter.sv
// Shares one AES decryption core between NUM_REQ requesters. Jobs are granted
// round-robin, operands latched, the core's level START/DONE handshake is
// sequenced, and the plaintext is returned to the originating requester.
//
// Ports:
//   CLK            system clock, rising edge
//   RESET          asynchronous active-low reset
//   bus            aes_job_arbiter_if.slave (request, response, core handshake)
//   BUSY           high in every state except IDLE
//   GRANT_ID       current or last granted requester
//   STAT_JOBS      completed jobs including aborts, saturating
//   STAT_TIMEOUTS  timeout aborts, saturating
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for any REQ_VALID; grant decided and latched here
// S_LOAD  | operands settle on AES_KEY/AES_MSG_ENC, START low, REQ_READY pulse
// S_RUN   | START high, waiting for DONE or timeout
// S_DRAIN | START low, waiting for the core to drop DONE
// S_RESP  | RSP_VALID to the granted requester until it accepts
module aes_job_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                CLK,
    input  logic                RESET,
    aes_job_arbiter_if.slave    bus,
    output logic                BUSY,
    output logic [1:0]          GRANT_ID,
    output logic [15:0]         STAT_JOBS,
    output logic [7:0]          STAT_TIMEOUTS
);
    localparam int             CW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_RESP} state_t;

    state_t               state_q, state_d;
    logic [1:0]           grant_q, grant_d;
    logic [NUM_REQ-1:0]   ready_q, ready_d;
    logic [127:0]         key_q, key_d, msg_q, msg_d, res_q, res_d;
    logic                 err_q, err_d;
    logic [CW-1:0]        tmo_q, tmo_d;
    logic [15:0]          jobs_q, jobs_d;
    logic [7:0]           tmos_q, tmos_d;

    logic                 found;
    logic [1:0]           winner, cand;
    logic [3:0]           valid_ext, rdy_ext;
    logic [NUM_REQ-1:0]   win_oh;
    logic [127:0]         key_sel, msg_sel;

    // Zero-extended to 4 bits so a 2-bit requester index always fits.
    assign valid_ext = 4'(bus.REQ_VALID);
    assign rdy_ext   = 4'(bus.RSP_READY);

    // Round-robin: walk from the requester after the last grant, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = grant_q;
        cand   = grant_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (cand == 2'(NUM_REQ - 1)) ? 2'd0 : cand + 2'd1;
            if (!found && valid_ext[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        win_oh  = '0;
        key_sel = '0;
        msg_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == 2'(i)) begin
                win_oh[i] = 1'b1;
                key_sel   = bus.REQ_KEY[i*128 +: 128];
                msg_sel   = bus.REQ_MSG[i*128 +: 128];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            grant_q <= 2'(NUM_REQ - 1);
            ready_q <= '0;
            key_q   <= '0;
            msg_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
            jobs_q  <= '0;
            tmos_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ready_q <= ready_d;
            key_q   <= key_d;
            msg_q   <= msg_d;
            res_q   <= res_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            jobs_q  <= jobs_d;
            tmos_q  <= tmos_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ready_d = '0;
        key_d   = key_q;
        msg_d   = msg_q;
        res_d   = res_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        jobs_d  = jobs_q;
        tmos_d  = tmos_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    ready_d = win_oh;
                    grant_d = winner;
                    key_d   = key_sel;
                    msg_d   = msg_sel;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                tmo_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                // DONE is checked first so it wins a same-cycle timeout.
                if (bus.AES_DONE) begin
                    res_d   = bus.AES_MSG_DEC;
                    err_d   = 1'b0;
                    state_d = S_DRAIN;
                end else if (tmo_q == TMO_LAST) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    if (tmos_q != 8'hFF) tmos_d = tmos_q + 8'd1;
                    state_d = S_DRAIN;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (!bus.AES_DONE) state_d = S_RESP;
            end
            S_RESP: begin
                if (rdy_ext[grant_q]) begin
                    if (jobs_q != 16'hFFFF) jobs_d = jobs_q + 16'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.RSP_VALID = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.RSP_VALID[i] = (state_q == S_RESP) && (grant_q == 2'(i));
        end
    end

    assign bus.REQ_READY   = ready_q;
    assign bus.RSP_DATA    = res_q;
    assign bus.RSP_ERR     = err_q;
    assign bus.AES_START   = (state_q == S_RUN);
    assign bus.AES_KEY     = key_q;
    assign bus.AES_MSG_ENC = msg_q;
    assign BUSY            = (state_q != S_IDLE);
    assign GRANT_ID        = grant_q;
    assign STAT_JOBS       = jobs_q;
    assign STAT_TIMEOUTS   = tmos_q;
endmodule
